aes_key_sched: RTL and testbench
================================

Name: aes_key_sched

Overview:
Sequential AES key-expansion engine generalising the per-round combinational key generator to AES-128, AES-192 and AES-256 (FIPS-197). On start it loads the cipher key and produces one 32-bit schedule word per clock into an internal word store. Once done, any round key 0..Nr is readable by index. It sits between key-load control and the round datapath, so the datapath can fetch round keys in any order, including reverse order for decryption.

Parameters:
MAX_NK, 8, largest supported key length in 32-bit words (4, 6 or 8); sets storage depth 4*(MAX_NK+7) words and key_in width.
KEY_W, 32*MAX_NK, derived; width of key_in.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request expansion of key_in; sampled only in IDLE
key_len  in  2  0=AES-128 (Nk=4,Nr=10), 1=AES-192 (Nk=6,Nr=12), 2=AES-256 (Nk=8,Nr=14), 3=reserved
key_in  in  KEY_W  cipher key, MSB-aligned; word 0 = key_in[KEY_W-1 -: 32]; unused LSBs ignored
busy  out  1  expansion in progress
done  out  1  one-cycle pulse when last word written
rk_valid  out  1  schedule complete and readable
err  out  1  one-cycle pulse on rejected start
rk_idx  in  4  round-key index to read
rk_out  out  128  round key rk_idx = {w[4r], w[4r+1], w[4r+2], w[4r+3]}

Behaviour:
- Reset: busy=0, done=0, rk_valid=0, err=0, FSM=IDLE, word counter=0, Rcon=0x01. Store contents need not be cleared; rk_out=0 while rk_valid=0.
- FSM IDLE -> GEN -> IDLE.
- IDLE with start=1 and legal key_len (Nk<=MAX_NK, key_len!=3): latch Nk/Nr, write w[0..Nk-1] from key_in in one cycle, set i=Nk, Rcon=0x01, clear rk_valid, go to GEN.
- IDLE with start=1 and illegal key_len: err=1 for one cycle. State unchanged, rk_valid unchanged.
- GEN, one word per cycle: temp=w[i-1].
  - If i mod Nk==0: temp=SubWord(RotWord(temp)) ^ {Rcon,24'h0}, then Rcon=xtime(Rcon) (0x80 -> 0x1B).
  - Else if Nk==8 and i mod Nk==4: temp=SubWord(temp).
  - w[i]=w[i-Nk]^temp; i++.
- Use a modulo counter for i mod Nk; no divider.
- Last word index is 4*(Nr+1)-1 (43/51/59). Cycle counts: 40 / 46 / 52 GEN cycles.
- busy=1 exactly during GEN cycles.
- On the edge writing the last word: go to IDLE. In the next cycle busy=0, done=1 (one cycle), rk_valid=1.
- rk_valid stays 1 until the next accepted start or reset.
- start while busy is ignored: no err, no restart.
- rk_out is combinational from rk_idx and the store in the base build. rk_idx>Nr gives rk_out=0.
- Reset mid-GEN returns to IDLE next cycle with rk_valid=0. A partial schedule is never flagged valid.
- SubWord: four parallel combinational S-box lookups; one S-box word instance shared by both temp paths.

Optional Feature:
KEY_SCHED_REGOUT_EN:
- Defined: rk_out is registered. It reflects rk_idx one cycle later (1-cycle read latency) and resets to 0. The out-of-range and !rk_valid zeroing is applied at register input.
- Undefined: combinational read, 0-cycle latency.
- FSM timing is identical in both builds.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle -> busy 40 cycles, done pulse, rk_out[1]=a0fafe1788542cb123a339392a6c7605, rk_out[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> busy 46 cycles, rk_out[12]=e98ba06f448c773c8ecc720401002202, rk_out[13]=0.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> busy 52 cycles, rk_out[14]=fe4890d1e6188d0b046df344706c631e, rk_out[0]=key_in[255:128].
- key_len=3 start -> err pulse 1 cycle, busy stays 0, rk_valid unchanged. Then start during busy -> ignored, result still matches the first key.
- rst asserted at GEN cycle 20 -> next cycle busy=0, rk_valid=0, no done. A fresh AES-128 start then gives correct vectors.
- KEY_SCHED_REGOUT_EN build: sweep rk_idx 10..0 after done -> each key appears one cycle after its index, matching the AES-128 vectors.

Source files
------------

// File: rtl/aes_key_sched.sv
// Sequential AES-128/192/256 key expansion. It writes one schedule word per cycle, and round keys are then read back by index.
// Define KEY_SCHED_REGOUT_EN to register rk_out, which gives a 1-cycle read latency.
module aes_key_sched #(
    parameter int MAX_NK = 8,
    parameter int KEY_W  = 32*MAX_NK
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_key_len,
    input  logic [KEY_W-1:0] i_key_in,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_rk_valid,
    output logic             o_err,
    input  logic [3:0]       i_rk_idx,
    output logic [127:0]     o_rk_out
);
    localparam int DEPTH = 4*(MAX_NK+7);
    localparam int IW    = $clog2(DEPTH);

    typedef enum logic {S_IDLE, S_GEN} state_t;

    // GF(2^8) multiply, reduced by the AES polynomial
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse (x^254) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq, inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_i, r_last;
    logic [2:0]    r_mod;
    logic [3:0]    r_nk, r_nr;
    logic [7:0]    r_rcon;
    logic          r_done, r_err, r_rk_valid;
    logic [31:0]   r_w [DEPTH];

    logic [3:0]    w_nk, w_nr;
    logic          w_legal, w_accept, w_reject, w_last;
    logic [31:0]   w_prev, w_back, w_sub_in, w_sub, w_temp, w_new;
    logic          w_rd_ok;
    logic [IW-1:0] w_base;
    logic [127:0]  w_rk;

    always_comb begin
        w_nk = 4'd4;
        w_nr = 4'd10;
        case (i_key_len)
            2'd1:    begin w_nk = 4'd6; w_nr = 4'd12; end
            2'd2:    begin w_nk = 4'd8; w_nr = 4'd14; end
            default: ;
        endcase
        w_legal = (i_key_len != 2'd3) && (int'(w_nk) <= MAX_NK);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_last      = 1'b0;
        o_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_legal) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_GEN;
                    end else begin
                        w_reject    = 1'b1;
                    end
                end
            end
            S_GEN: begin
                o_busy = 1'b1;
                if (r_i == r_last) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One S-box word serves both the RotWord+Rcon path and the Nk=8 mid-key path
    assign w_prev   = r_w[r_i - IW'(1)];
    assign w_back   = r_w[r_i - IW'(r_nk)];
    assign w_sub_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign w_sub    = sub_word(w_sub_in);

    always_comb begin
        w_temp = w_prev;
        if (r_mod == 3'd0)                         w_temp = w_sub ^ {r_rcon, 24'h0};
        else if (r_nk == 4'd8 && r_mod == 3'd4)    w_temp = w_sub;
    end
    assign w_new = w_back ^ w_temp;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_i        <= '0;
            r_last     <= '0;
            r_mod      <= 3'd0;
            r_nk       <= 4'd4;
            r_nr       <= 4'd0;
            r_rcon     <= 8'h01;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rk_valid <= 1'b0;
        end else begin
            r_done <= w_last;
            r_err  <= w_reject;
            if (w_accept) begin
                r_nk       <= w_nk;
                r_nr       <= w_nr;
                r_last     <= IW'({w_nr, 2'b11});
                r_i        <= IW'(w_nk);
                r_mod      <= 3'd0;
                r_rcon     <= 8'h01;
                r_rk_valid <= 1'b0;
            end else if (r_state == S_GEN) begin
                r_i   <= r_i + IW'(1);
                r_mod <= ({1'b0, r_mod} == r_nk - 4'd1) ? 3'd0 : r_mod + 3'd1;
                if (r_mod == 3'd0)
                    r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
                if (w_last) r_rk_valid <= 1'b1;
            end
        end
    end

    // Word store has no reset; validity is tracked solely by r_rk_valid
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            for (int k = 0; k < MAX_NK; k++)
                if (k < int'(w_nk)) r_w[k] <= i_key_in[KEY_W-1-32*k -: 32];
        end else if (r_state == S_GEN) begin
            r_w[r_i] <= w_new;
        end
    end

    assign w_rd_ok = r_rk_valid && (i_rk_idx <= r_nr);
    assign w_base  = w_rd_ok ? IW'({i_rk_idx, 2'b00}) : '0;
    assign w_rk    = w_rd_ok ? {r_w[w_base], r_w[w_base + IW'(1)],
                                r_w[w_base + IW'(2)], r_w[w_base + IW'(3)]} : '0;

`ifdef KEY_SCHED_REGOUT_EN
    logic [127:0] r_rk_out;
    always_ff @(posedge i_clk) begin
        if (i_rst) r_rk_out <= '0;
        else       r_rk_out <= w_rk;
    end
    assign o_rk_out = r_rk_out;
`else
    assign o_rk_out = w_rk;
`endif

    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_rk_valid = r_rk_valid;
endmodule

// File: tb/tb_aes_key_sched.sv
// Scoreboard bench for aes_key_sched: the stimulus queues the expected done, err and read results, and a negedge monitor checks them.
module tb_aes_key_sched;
    logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [1:0]   key_len = 2'd0;
    logic [255:0] key_in = '0;
    logic [3:0]   rk_idx = 4'd0;
    logic         busy, done, rk_valid, err;
    logic [127:0] rk_out;

    aes_key_sched #(.MAX_NK(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_key_len(key_len), .i_key_in(key_in),
        .o_busy(busy), .o_done(done), .o_rk_valid(rk_valid), .o_err(err),
        .i_rk_idx(rk_idx), .o_rk_out(rk_out)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int q_done[$];
    int q_err[$];
    logic [127:0] q_rd[$];
    logic rd_req = 1'b0, rd_d = 1'b0, rd_now;
    int bcnt = 0;

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic [127:0] rk128 [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: read results, done pulses with their busy-cycle count, and err pulses
    always @(posedge clk) rd_d <= rd_req;
    always @(negedge clk) begin
`ifdef KEY_SCHED_REGOUT_EN
        rd_now = rd_d;
`else
        rd_now = rd_req;
`endif
        if (rd_now) begin
            if (q_rd.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_unexpected: got %h want none", rk_out);
            end else chk("rk_out", rk_out, q_rd.pop_front());
        end
        if (rst) bcnt = 0;
        else if (busy) bcnt++;
        if (done) begin
            if (q_done.size() == 0) begin
                total++; bad++;
                $display("FAIL done_unexpected: got done=1 want 0");
            end else begin
                chk("busy_cycles", bcnt, q_done.pop_front());
                chk("valid_at_done", rk_valid, 1);
            end
            bcnt = 0;
        end
        if (err) begin
            total++;
            if (q_err.size() == 0) begin
                bad++;
                $display("FAIL err_unexpected: got err=1 want 0");
            end else void'(q_err.pop_front());
        end
    end

    task automatic start_key(input logic [1:0] len, input logic [255:0] key, input int exp_cnt, input bit exp_err);
        @(posedge clk); #1;
        start = 1'b1; key_len = len; key_in = key;
        if (exp_cnt > 0) q_done.push_back(exp_cnt);
        if (exp_err) q_err.push_back(1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic rd(input logic [3:0] idx, input logic [127:0] exp);
        @(posedge clk); #1;
        rk_idx = idx;
        q_rd.push_back(exp);
        rd_req = 1'b1;
    endtask

    task automatic rd_end();
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    task automatic sweep128();
        for (int r = 10; r >= 0; r--) rd(4'(r), rk128[r]);
        rd(4'd11, '0);
        rd(4'd15, '0);
        rd_end();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", rk_valid, 0);
        chk("rst_rk_out", rk_out, 0);
        @(posedge clk); #1 rst = 1'b0;
        rd(4'd0, '0);
        rd_end();

        // AES-128 with junk in the unused LSBs
        start_key(2'd0, {K128, 128'hdeadbeefcafef00d0123456789abcdef}, 40, 1'b0);
        wait_done();
        sweep128();

        // Reserved key_len is rejected and the stored schedule is left intact
        start_key(2'd3, K256, 0, 1'b1);
        repeat (3) @(negedge clk);
        chk("rej_busy", busy, 0);
        chk("rej_valid", rk_valid, 1);
        rd(4'd10, rk128[10]);
        rd_end();

        // A second start issued while busy must be ignored
        start_key(2'd0, {K128, 128'h0}, 40, 1'b0);
        repeat (5) @(posedge clk);
        start_key(2'd2, K256, 0, 1'b0);
        wait_done();
        rd(4'd10, rk128[10]);
        rd(4'd1, rk128[1]);
        rd(4'd14, '0);
        rd_end();

        start_key(2'd1, {K192, 64'h5555aaaa5555aaaa}, 46, 1'b0);
        wait_done();
        rd(4'd0, 128'h8e73b0f7da0e6452c810f32b809079e5);
        rd(4'd1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        rd(4'd12, 128'he98ba06f448c773c8ecc720401002202);
        rd(4'd13, '0);
        rd_end();

        start_key(2'd2, K256, 52, 1'b0);
        wait_done();
        rd(4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
        rd(4'd0, K256[255:128]);
        rd(4'd1, K256[127:0]);
        rd(4'd15, '0);
        rd_end();

        // Reset partway through generation
        start_key(2'd0, {K128, 128'h0}, 0, 1'b0);
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", rk_valid, 0);
        chk("midrst_done", done, 0);
        repeat (40) @(negedge clk);
        rd(4'd10, '0);
        rd_end();

        start_key(2'd0, {K128, 128'h0}, 40, 1'b0);
        wait_done();
        sweep128();

        repeat (3) @(posedge clk);
        chk("q_done_empty", q_done.size(), 0);
        chk("q_err_empty", q_err.size(), 0);
        chk("q_rd_empty", q_rd.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
